pattern_select_ctrl: RTL and testbench
======================================

// Module: pattern_select_ctrl
// PURPOSE
//   Upstream of the VGA test-pattern top: produces its 3-bit pattern select from a raw push button.
//   Synchronises and debounces the button; each debounced press advances a pending pattern index.
//   The pending index goes to the pattern bus only at a frame boundary (vsync falling edge), so the
//   display never tears mid-frame. Runs in the 25 MHz pixel clock domain with the sync generator.
// PARAMETERS
//   PATTERN_WIDTH    3       width of o_pattern
//   NUM_PATTERNS     8       valid indices 0..NUM_PATTERNS-1; must be <= 2**PATTERN_WIDTH, >= 2
//   DEBOUNCE_CYCLES  250000  stable cycles needed to accept a level change (10 ms @ 25 MHz); >= 2
//   AUTO_FRAMES      120     frames between automatic advances (used only with the macro); >= 1
// PORTS
//   i_clk        in   1              pixel clock, 25 MHz
//   i_rst_n      in   1              asynchronous active-low reset
//   i_button     in   1              raw button, active-high, asynchronous, may bounce
//   i_vsync      in   1              vsync from the sync generator, i_clk-synchronous, active-low pulse
//   o_pattern    out  PATTERN_WIDTH  applied pattern index, to the test-pattern generator
//   o_pending    out  1              1 = a new index is waiting for the next frame boundary
//   o_btn_level  out  1              debounced button level
// BEHAVIOUR
//   Reset (async assert, sync release): o_pattern=0, o_pending=0, o_btn_level=0, pending index=0,
//     debounce count=0, FSM=S_RELEASED, vsync history=1, 2-FF synchroniser=0.
//     Reset mid-operation discards any pending index and any partial debounce count.
//   Synchroniser: i_button passes through 2 flops (btn_s) before any logic.
//   Debounce FSM, 4 states:
//     S_RELEASED     : btn_s=1 -> S_PRESS_WAIT, count=0.
//     S_PRESS_WAIT   : btn_s=0 -> S_RELEASED. Otherwise count++; at count==DEBOUNCE_CYCLES-1 ->
//                      S_PRESSED, o_btn_level<=1, press strobe for 1 cycle.
//     S_PRESSED      : btn_s=0 -> S_RELEASE_WAIT, count=0.
//     S_RELEASE_WAIT : btn_s=1 -> S_PRESSED. Otherwise count++; at count==DEBOUNCE_CYCLES-1 ->
//                      S_RELEASED, o_btn_level<=0.
//     Count width = clog2(DEBOUNCE_CYCLES). A glitch shorter than DEBOUNCE_CYCLES never changes state.
//   Press handling: on the press strobe, pending index <= (pending == NUM_PATTERNS-1) ? 0 : pending+1,
//     o_pending<=1. Presses accumulate: two presses inside one frame advance the index by 2.
//     The pending index always starts from the current o_pattern when o_pending=0.
//   Frame boundary: vsync_d is i_vsync delayed 1 cycle; boundary = vsync_d & ~i_vsync.
//     On a boundary with o_pending=1: o_pattern <= pending index, o_pending <= 0 (registered;
//     visible on the edge after the cycle in which i_vsync is first sampled low).
//     On a boundary with o_pending=0: o_pattern holds.
//   Press and boundary in the same cycle: the incremented index is applied straight to o_pattern
//     and o_pending ends at 0.
//   Latency: button edge -> press strobe = 2 sync + DEBOUNCE_CYCLES cycles; strobe -> o_pattern at
//     the next vsync falling edge.
// CONFIGURATION
//   PATTERN_AUTO_CYCLE_EN defined:
//     - A frame counter (clog2(AUTO_FRAMES) bits) increments on every boundary.
//     - At a boundary with count==AUTO_FRAMES-1 and o_pending=0: o_pattern advances by 1 with the
//       same wrap rule, and the counter resets to 0.
//     - A manual press strobe resets the frame counter to 0. A manual pending index has priority
//       over the auto advance.
//   Not defined: no frame counter. o_pattern changes only via button presses. Port list is identical.
// TESTING  (bench uses DEBOUNCE_CYCLES=16, AUTO_FRAMES=3, NUM_PATTERNS=8)
//   1. Reset: assert i_rst_n=0 mid-run -> all outputs 0 immediately; release -> o_pattern stays 0
//      with no button activity.
//   2. Bounce: pulse i_button high for 10 cycles, 5 times -> o_btn_level stays 0, o_pending stays 0.
//      Then hold high for 30 cycles -> o_btn_level=1 at 18 cycles, o_pending=1.
//   3. Frame apply: after one press, o_pattern stays 0 until the vsync falling edge; the next cycle
//      gives o_pattern=1, o_pending=0.
//   4. Accumulate and wrap: from o_pattern=6, three presses inside one frame -> at the boundary
//      o_pattern=1 (6->7->0->1).
//   5. Simultaneous: press strobe coincides with the boundary cycle from o_pattern=2 -> o_pattern=3,
//      o_pending=0.
//   6. With PATTERN_AUTO_CYCLE_EN and no presses: o_pattern goes 0->1->2 every 3rd boundary.
//      A press in frame 2 resets the counter and the press value is applied.

Source files
------------

// File: rtl/pattern_select_ctrl.sv
// Button-driven test-pattern selector: 2-FF synchroniser, debounce FSM, and a pending index that is
// applied to o_pattern only at a vsync falling edge. Define PATTERN_AUTO_CYCLE_EN for frame-timed auto advance.
module pattern_select_ctrl #(
  parameter int PATTERN_WIDTH   = 3,
  parameter int NUM_PATTERNS    = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_button,
  input  logic                     i_vsync,
  output logic [PATTERN_WIDTH-1:0] o_pattern,
  output logic                     o_pending,
  output logic                     o_btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PATTERN_WIDTH-1:0] LAST_IDX = PATTERN_WIDTH'(NUM_PATTERNS - 1);

  generate
    if (NUM_PATTERNS < 2 || NUM_PATTERNS > 2**PATTERN_WIDTH || DEBOUNCE_CYCLES < 2 || AUTO_FRAMES < 1)
    begin : g_bad_params
      $error("pattern_select_ctrl: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic                     btn_meta_reg, btn_s_reg;
  logic                     level_reg, level_next;
  logic                     vsync_d_reg;
  logic [PATTERN_WIDTH-1:0] pattern_reg, pattern_next;
  logic [PATTERN_WIDTH-1:0] pend_idx_reg, pend_idx_next;
  logic                     pending_reg, pending_next;
  logic                     press_strobe;
  logic                     boundary;
  logic [PATTERN_WIDTH-1:0] base_idx, inc_idx;

`ifdef PATTERN_AUTO_CYCLE_EN
  localparam int FRAME_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(AUTO_FRAMES - 1);
  logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
`endif

  assign boundary = vsync_d_reg & ~i_vsync;
  // Increments chain off the pending index so several presses in one frame accumulate.
  assign base_idx = pending_reg ? pend_idx_reg : pattern_reg;
  assign inc_idx  = (base_idx == LAST_IDX) ? '0 : base_idx + PATTERN_WIDTH'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta_reg  <= 1'b0;
      btn_s_reg     <= 1'b0;
      state_reg     <= S_RELEASED;
      cnt_reg       <= '0;
      level_reg     <= 1'b0;
      vsync_d_reg   <= 1'b1;
      pattern_reg   <= '0;
      pend_idx_reg  <= '0;
      pending_reg   <= 1'b0;
`ifdef PATTERN_AUTO_CYCLE_EN
      frame_cnt_reg <= '0;
`endif
    end else begin
      btn_meta_reg  <= i_button;
      btn_s_reg     <= btn_meta_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      level_reg     <= level_next;
      vsync_d_reg   <= i_vsync;
      pattern_reg   <= pattern_next;
      pend_idx_reg  <= pend_idx_next;
      pending_reg   <= pending_next;
`ifdef PATTERN_AUTO_CYCLE_EN
      frame_cnt_reg <= frame_cnt_next;
`endif
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive agreeing samples.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_strobe = 1'b0;
    case (state_reg)
      S_RELEASED: begin
        if (btn_s_reg) begin
          state_next = S_PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!btn_s_reg) begin
          state_next = S_RELEASED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = S_PRESSED;
          level_next   = 1'b1;
          press_strobe = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!btn_s_reg) begin
          state_next = S_RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (btn_s_reg) begin
          state_next = S_PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = S_RELEASED;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    pattern_next  = pattern_reg;
    pend_idx_next = pend_idx_reg;
    pending_next  = pending_reg;
    if (press_strobe) begin
      pend_idx_next = inc_idx;
      pending_next  = 1'b1;
    end
    if (boundary) begin
      if (press_strobe) begin
        pattern_next = inc_idx;
        pending_next = 1'b0;
      end else if (pending_reg) begin
        pattern_next = pend_idx_reg;
        pending_next = 1'b0;
      end
`ifdef PATTERN_AUTO_CYCLE_EN
      // Nothing pending here, so inc_idx is o_pattern + 1.
      else if (frame_cnt_reg == FRAME_LAST) begin
        pattern_next = inc_idx;
      end
`endif
    end
  end

`ifdef PATTERN_AUTO_CYCLE_EN
  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    if (press_strobe) begin
      frame_cnt_next = '0;
    end else if (boundary) begin
      frame_cnt_next = (frame_cnt_reg == FRAME_LAST) ? '0 : frame_cnt_reg + FRAME_W'(1);
    end
  end
`endif

  assign o_pattern   = pattern_reg;
  assign o_pending   = pending_reg;
  assign o_btn_level = level_reg;

endmodule

// File: tb/tb_pattern_select_ctrl.sv
// Randomised and directed bench for pattern_select_ctrl against a run-length / modulo reference model.
module tb_pattern_select_ctrl;

  localparam int PW  = 3;
  localparam int NP  = 8;
  localparam int DEB = 16;
  localparam int AF  = 3;
  localparam int FL  = 300;   // frame length in cycles; vsync low for the last 2

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          button = 1'b0;
  logic          vsync = 1'b1;
  logic [PW-1:0] pattern;
  logic          pending;
  logic          btn_level;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int s1_m, s2_m, lvl_m, run_m, vsd_m, pat_m, pidx_m, pflag_m, frames_m;
  int pos = 0;

  pattern_select_ctrl #(
    .PATTERN_WIDTH  (PW),
    .NUM_PATTERNS   (NP),
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_FRAMES    (AF)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_button   (button),
    .i_vsync    (vsync),
    .o_pattern  (pattern),
    .o_pending  (pending),
    .o_btn_level(btn_level)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s1_m = 0; s2_m = 0; lvl_m = 0; run_m = 0; vsd_m = 1;
    pat_m = 0; pidx_m = 0; pflag_m = 0; frames_m = 0;
  endtask

  // One clock: drive inputs, advance model with the values seen at the edge, compare #1 later.
  task automatic step(input logic b);
    int vs, bnd, prs, base, inc;
    vs = (pos >= FL - 2) ? 0 : 1;
    button = b;
    vsync  = vs[0];
    @(posedge clk);
    if (rst_n) begin
      prs = 0;
      run_m = (s2_m != lvl_m) ? run_m + 1 : 0;
      if (run_m == DEB + 1) begin
        lvl_m = 1 - lvl_m;
        run_m = 0;
        prs   = lvl_m;
      end
      s2_m = s1_m;
      s1_m = int'(b);
      bnd   = (vsd_m == 1 && vs == 0) ? 1 : 0;
      vsd_m = vs;
      base = (pflag_m != 0) ? pidx_m : pat_m;
      inc  = (base + 1) % NP;
      if (prs != 0) begin
        pidx_m  = inc;
        pflag_m = 1;
      end
      if (bnd != 0) begin
        if (prs != 0) begin
          pat_m = inc; pflag_m = 0;
        end else if (pflag_m != 0) begin
          pat_m = pidx_m; pflag_m = 0;
        end
`ifdef PATTERN_AUTO_CYCLE_EN
        else if (frames_m == AF - 1) begin
          pat_m = (pat_m + 1) % NP;
        end
`endif
      end
`ifdef PATTERN_AUTO_CYCLE_EN
      if (prs != 0) frames_m = 0;
      else if (bnd != 0) frames_m = (frames_m + 1) % AF;
`endif
    end
    pos = (pos + 1) % FL;
    #1;
    check("pattern", 32'(pattern), 32'(pat_m));
    check("pending", 32'(pending), 32'(pflag_m));
    check("btn_level", 32'(btn_level), 32'(lvl_m));
  endtask

  task automatic wait_pos(input int p);
    while (pos != p) step(1'b0);
  endtask

  task automatic press_once();
    repeat (DEB + 6) step(1'b1);
    repeat (DEB + 6) step(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pattern", 32'(pattern), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    model_reset();
    repeat (3) step(1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic b;
    model_reset();
    #5;
    do_reset();

    // Idle frame: nothing moves
    repeat (FL) step(1'b0);
    wait_pos(0);
`ifndef PATTERN_AUTO_CYCLE_EN
    check("idle_pattern", 32'(pattern), 32'd0);
`endif

    // Bounce: short pulses must be rejected, then a long hold is accepted
    repeat (5) begin
      repeat (10) step(1'b1);
      repeat (10) step(1'b0);
    end
    check("bounce_level", 32'(btn_level), 32'd0);
    check("bounce_pending", 32'(pending), 32'd0);
    repeat (30) step(1'b1);
    check("hold_level", 32'(btn_level), 32'd1);
    check("hold_pending", 32'(pending), 32'd1);
    check("hold_pattern", 32'(pattern), 32'd0);
    repeat (30) step(1'b0);
    wait_pos(0);
`ifndef PATTERN_AUTO_CYCLE_EN
    check("apply_pattern", 32'(pattern), 32'd1);
    check("apply_pending", 32'(pending), 32'd0);
`endif

    // Five presses in one frame: 1 -> 6, then three more wrap to 1
    repeat (5) press_once();
    wait_pos(0);
`ifndef PATTERN_AUTO_CYCLE_EN
    check("accum_pattern", 32'(pattern), 32'd6);
`endif
    repeat (3) press_once();
    wait_pos(0);
`ifndef PATTERN_AUTO_CYCLE_EN
    check("wrap_pattern", 32'(pattern), 32'd1);
`endif
    press_once();
    wait_pos(0);
`ifndef PATTERN_AUTO_CYCLE_EN
    check("to2_pattern", 32'(pattern), 32'd2);
`endif

    // Press strobe lands on the boundary cycle: first low vsync at pos FL-2, strobe DEB+2 edges after rise
    wait_pos(FL - 2 - (DEB + 2));
    repeat (30) step(1'b1);
    repeat (30) step(1'b0);
`ifndef PATTERN_AUTO_CYCLE_EN
    check("simul_pattern", 32'(pattern), 32'd3);
    check("simul_pending", 32'(pending), 32'd0);
`endif

    // Mid-run reset discards state
    repeat (20) step(1'b1);
    do_reset();
    repeat (FL) step(1'b0);
    check("post_rst_pattern", 32'(pattern), 32'd0);

    // Random bouncing button across several frames, with a reset in the middle
    b = 1'b0;
    for (int k = 0; k < 60; k++) begin
      b = ~b;
      repeat ($urandom_range(1, 45)) step(b);
      if (k == 30) do_reset();
    end
    repeat (FL * 4) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
